// File: rtl/ftofix_pkg.sv
// Shared constants and helpers for the float-to-fixed result path.
//   FTOFIX_LATENCY : enabled-clock depth of the float-to-fixed converter
//   FTOFIX_WIDTH   : data width of float in / fixed out
//   clog2()        : ceiling log2, used for pointer and occupancy widths
package ftofix_pkg;

    localparam int unsigned FTOFIX_LATENCY = 6;
    localparam int unsigned FTOFIX_WIDTH   = 32;

    // Ceiling log2; clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(value)) begin
                result = 32'(i + 1);
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/ftofix_sync_fifo.sv
// Single-clock FIFO holding converter results until the consumer takes them.
//   clk, reset_n : clock, synchronous active-low reset (memory not reset)
//   wr, wr_data  : push request and data (caller guarantees space)
//   rd           : pop request, ignored while empty
//   rd_data      : head entry (combinational read of the head slot)
//   count, empty : occupancy and empty flag, both from registered state
module ftofix_sync_fifo
    import ftofix_pkg::*;
#(
    parameter int unsigned WIDTH = FTOFIX_WIDTH,
    parameter int unsigned DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd,
    output logic [WIDTH-1:0]      rd_data,
    output logic [clog2(DEPTH):0] count,
    output logic                  empty
);

    localparam int unsigned AW = clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             rd_en;

    assign empty   = (count == '0);
    assign rd_en   = rd & ~empty;
    assign rd_data = mem[rd_ptr];

    // Storage: deliberately not reset, only the pointers qualify it.
    always_ff @(posedge clk) begin
        if (wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(wr) - CW'(rd_en);
        end
    end

`ifndef SYNTHESIS
    // Admission credit should make a push into a full FIFO impossible.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            assert (!(wr && !rd_en && count == CW'(DEPTH)))
                else $error("ftofix_sync_fifo: write into full FIFO");
        end
    end
`endif

endmodule

// File: rtl/ftofix_result_buffer.sv
// Companion stage of the float-to-fixed converter: drives the converter's
// clock enable and input, tags each accepted float through the converter's
// fixed-latency pipeline and captures the emerging result into a FIFO.
// Credit admission (FIFO entries + floats in flight) means no result is lost.
//   in_valid/in_data/in_ready    : upstream float handshake
//   conv_ce/conv_a/conv_result   : converter enable, operand and result
//   out_valid/out_data/out_ready : fixed-point result handshake
//   level                        : FIFO occupancy
// LATENCY must be >= 2; DEPTH a power of two, >= LATENCY+2 for full rate.
module ftofix_result_buffer
    import ftofix_pkg::*;
#(
    parameter int unsigned LATENCY = FTOFIX_LATENCY,
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned WIDTH   = FTOFIX_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    input  logic [WIDTH-1:0]      in_data,
    output logic                  in_ready,
    output logic                  conv_ce,
    output logic [WIDTH-1:0]      conv_a,
    input  logic [WIDTH-1:0]      conv_result,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_data,
    input  logic                  out_ready,
    output logic [clog2(DEPTH):0] level
);

    localparam int unsigned IW = clog2(LATENCY + 1);

    logic [LATENCY-1:0]    vpipe;
    logic [IW-1:0]         inflight;
    logic [clog2(DEPTH):0] count;
    logic [WIDTH-1:0]      head_data;
    logic                  empty;
    logic                  credit_ok;
    logic                  in_fire;
    logic                  wr;
    logic                  rd;

    // Credit uses registered state only; held low while in reset.
    assign credit_ok = (32'(count) + 32'(inflight)) < DEPTH;
    assign in_ready  = reset_n & credit_ok;
    assign in_fire   = in_valid & in_ready;

    // Converter only advances while something is entering or in flight.
    assign conv_ce = in_fire | (inflight != '0);
    assign conv_a  = in_data;

    // A tag leaving the last stage marks conv_result as a real result;
    // conv_ce is necessarily high then, so the tag leaves on the same edge.
    assign wr = vpipe[LATENCY-1];
    assign rd = out_valid & out_ready;

    // Valid tags move in lock-step with the converter stages.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            vpipe <= '0;
        end else if (conv_ce) begin
            vpipe <= {vpipe[LATENCY-2:0], in_fire};
        end
    end

    // Floats accepted but not yet written into the FIFO.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            inflight <= '0;
        end else begin
            inflight <= inflight + IW'(in_fire) - IW'(wr);
        end
    end

    ftofix_sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .wr      (wr),
        .wr_data (conv_result),
        .rd      (rd),
        .rd_data (head_data),
        .count   (count),
        .empty   (empty)
    );

    // Head is zeroed when empty so stale memory never reaches the consumer.
    assign out_valid = ~empty;
    assign out_data  = out_valid ? head_data : '0;
    assign level     = count;

endmodule

// File: tb/tb_ftofix_result_buffer.sv
// Bench for ftofix_result_buffer: behavioural ce-gated converter (float to
// Q16.16), queue scoreboard filled on accepted inputs and drained by a
// monitor on delivered outputs, directed scenarios plus random traffic.
module tb_ftofix_result_buffer;
    import ftofix_pkg::*;

    localparam int unsigned LAT   = 6;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned W     = 32;
    localparam int unsigned LW    = clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [W-1:0]  in_data = '0;
    logic          in_ready;
    logic          conv_ce;
    logic [W-1:0]  conv_a;
    logic [W-1:0]  conv_result;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic          out_ready = 1'b0;
    logic [LW-1:0] level;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    ftofix_result_buffer #(.LATENCY(LAT), .DEPTH(DEPTH), .WIDTH(W)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .conv_ce     (conv_ce),
        .conv_a      (conv_a),
        .conv_result (conv_result),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .level       (level)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Float to Q16.16 by plain arithmetic: value = mant * 2^(exp-150).
    function automatic logic [31:0] f2q(input logic [31:0] f);
        int          e;
        logic [63:0] m;
        logic [63:0] v;
        e = int'(f[30:23]);
        m = {40'd0, 1'b1, f[22:0]};
        if (e == 0) return 32'd0;
        if (e >= 134) v = m << (e - 134);
        else          v = m >> (134 - e);
        if (f[31]) v = -v;
        return v[31:0];
    endfunction

    function automatic logic [31:0] int2f(input int k);
        int          p;
        logic [31:0] mant;
        p = 0;
        for (int i = 0; i < 31; i++) if ((k >> i) != 0) p = i;
        mant = 32'(k) << (23 - p);
        return {1'b0, 8'(127 + p), mant[22:0]};
    endfunction

    function automatic logic [31:0] rand_float();
        return {1'($urandom_range(0, 1)), 8'($urandom_range(112, 140)), 23'($urandom)};
    endfunction

    // Behavioural converter: LAT stages, frozen when conv_ce is low, never reset.
    logic [W-1:0] cpipe [LAT];
    always @(posedge clk) begin
        if (conv_ce) begin
            cpipe[0] <= f2q(conv_a);
            for (int i = 1; i < LAT; i++) cpipe[i] <= cpipe[i-1];
        end
    end
    assign conv_result = cpipe[LAT-1];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard and history, written only by the monitor.
    logic [W-1:0] exp_q [$];
    int           fire_cycs [$];
    int           out_cycs [$];
    logic [W-1:0] out_vals [$];
    int           outstanding = 0;
    int           in_stalls = 0;
    logic         prev_stall = 1'b0;
    logic [W-1:0] prev_data = '0;

    always @(negedge clk) begin
        if (!reset_n) begin
            exp_q.delete();
            outstanding = 0;
            prev_stall  = 1'b0;
        end else begin
            // Accepted-but-undelivered results may never exceed the FIFO size.
            check("in_ready_credit", 64'(in_ready), 64'(outstanding < int'(DEPTH)));
            if (prev_stall) begin
                check("stall_valid_hold", 64'(out_valid), 64'd1);
                check("stall_data_hold", 64'(out_data), 64'(prev_data));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_output: got %0h expected no output (cycle %0d)", out_data, cyc);
                end else begin
                    check("out_data", 64'(out_data), 64'(exp_q.pop_front()));
                end
                outstanding--;
                out_cycs.push_back(cyc);
                out_vals.push_back(out_data);
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(f2q(in_data));
                outstanding++;
                fire_cycs.push_back(cyc);
            end
            if (in_valid && !in_ready) in_stalls++;
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
    end

    task automatic send(input logic [31:0] d);
        in_valid = 1'b1;
        in_data  = d;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        tests++;
        fails++;
        $display("FAIL send_timeout: got in_ready=0 for 200 cycles expected acceptance");
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0 && !out_valid) begin
                @(posedge clk);
                #1;
                return;
            end
        end
        tests++;
        fails++;
        $display("FAIL drain_timeout: got %0d results pending expected 0", exp_q.size());
    endtask

    int fb;
    int ob;
    int spur;
    int lat_seen;

    initial begin
        // Reset state
        idle(2);
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_level", 64'(level), 64'd0);
        check("rst_conv_ce", 64'(conv_ce), 64'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // 1: single item, 1.5 -> 0x00018000, seven cycles after acceptance
        out_ready = 1'b1;
        fb = fire_cycs.size();
        ob = out_cycs.size();
        send(32'h3FC0_0000);
        lat_seen = 0;
        for (int t = 0; t < 20 && lat_seen == 0; t++) begin
            @(negedge clk);
            if (out_valid) begin
                lat_seen = 1;
                check("t1_conv_ce_idle", 64'(conv_ce), 64'd0);
            end
        end
        @(negedge clk);
        check("t1_single_cycle", 64'(out_valid), 64'd0);
        check("t1_count", 64'(out_cycs.size() - ob), 64'd1);
        if (out_cycs.size() > ob) begin
            check("t1_latency", 64'(out_cycs[ob] - fire_cycs[fb]), 64'd7);
            check("t1_data", 64'(out_vals[ob]), 64'h0001_8000);
        end
        idle(1);

        // 2: fill with 1.0..10.0 while the consumer is stalled
        out_ready = 1'b0;
        fb = fire_cycs.size();
        ob = out_cycs.size();
        fork
            for (int k = 1; k <= 10; k++) send(int2f(k));
            begin
                idle(25);
                @(negedge clk);
                check("t2_accepted", 64'(fire_cycs.size() - fb), 64'd8);
                check("t2_level_full", 64'(level), 64'd8);
                check("t2_in_ready_low", 64'(in_ready), 64'd0);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        check("t2_delivered", 64'(out_cycs.size() - ob), 64'd10);
        if (out_cycs.size() >= ob + 2) begin
            check("t2_first", 64'(out_vals[ob]), 64'h0001_0000);
            check("t2_second", 64'(out_vals[ob+1]), 64'h0002_0000);
        end

        // 3: 20-item stream at full rate
        out_ready = 1'b1;
        fb = fire_cycs.size();
        ob = out_cycs.size();
        spur = in_stalls;
        for (int k = 0; k < 20; k++) send(rand_float());
        drain();
        check("t3_no_backpressure", 64'(in_stalls - spur), 64'd0);
        check("t3_delivered", 64'(out_cycs.size() - ob), 64'd20);
        if (out_cycs.size() >= ob + 20) begin
            check("t3_first_latency", 64'(out_cycs[ob] - fire_cycs[fb]), 64'd7);
            check("t3_back_to_back", 64'(out_cycs[ob+19] - out_cycs[ob]), 64'd19);
        end

        // 4: count=7, one in flight, pop on the write cycle
        out_ready = 1'b0;
        ob = out_cycs.size();
        for (int k = 0; k < 7; k++) send(rand_float());
        idle(3);
        send(rand_float());
        idle(5);
        out_ready = 1'b1;
        @(negedge clk);
        check("t4_level_before", 64'(level), 64'd7);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("t4_level_after", 64'(level), 64'd7);
        drain();
        check("t4_delivered", 64'(out_cycs.size() - ob), 64'd8);

        // 5: reset with two stored and three in flight
        out_ready = 1'b0;
        send(rand_float());
        send(rand_float());
        idle(8);
        @(negedge clk);
        check("t5_level_pre", 64'(level), 64'd2);
        @(posedge clk);
        #1;
        send(rand_float());
        send(rand_float());
        send(rand_float());
        reset_n = 1'b0;
        @(negedge clk);
        check("t5_in_ready_rst", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        check("t5_out_valid", 64'(out_valid), 64'd0);
        check("t5_level", 64'(level), 64'd0);
        check("t5_conv_ce", 64'(conv_ce), 64'd0);
        check("t5_in_ready", 64'(in_ready), 64'd1);
        spur = 0;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            if (out_valid) spur++;
        end
        check("t5_no_spurious", 64'(spur), 64'd0);
        @(posedge clk);
        #1;

        // 6: consumer toggling ready during a 10-item stream
        ob = out_cycs.size();
        fork
            for (int k = 0; k < 10; k++) send(rand_float());
            for (int t = 0; t < 40; t++) begin
                out_ready = ~t[0];
                @(posedge clk);
                #1;
            end
        join
        drain();
        check("t6_delivered", 64'(out_cycs.size() - ob), 64'd10);

        // Random traffic on both sides
        ob = out_cycs.size();
        fork
            for (int k = 0; k < 60; k++) begin
                send(rand_float());
                idle($urandom_range(0, 2));
            end
            for (int t = 0; t < 300; t++) begin
                out_ready = ($urandom_range(0, 3) != 0);
                @(posedge clk);
                #1;
            end
        join
        drain();
        check("rand_delivered", 64'(out_cycs.size() - ob), 64'd60);
        @(negedge clk);
        check("end_level", 64'(level), 64'd0);
        check("end_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ftofix_result_buffer.md
Name: ftofix_result_buffer

Overview:
- Downstream companion stage of the float-to-fixed converter wrapper. Issues the converter's clock enable and feeds its input.
- Tracks each float in flight through the converter's fixed-latency pipeline, which has no valid signal. Captures each emerging fixed-point result into a small FIFO.
- Presents the results to the consumer with a valid/ready handshake.
- Credit-based admission guarantees no result is ever lost.

Parameters:
- LATENCY, 6: enabled-clock pipeline depth of the float-to-fixed converter; must be ≥2.
- DEPTH, 8: result FIFO entries; power of two, must be ≥ LATENCY+2 for full throughput.
- WIDTH, 32: data width of float in and fixed out.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- in_valid  in  1  upstream presents a float this cycle
- in_data  in  WIDTH  IEEE-754 single float from upstream
- in_ready  out  1  block accepts in_data this cycle
- conv_ce  out  1  drives converter ce
- conv_a  out  WIDTH  drives converter a; equals in_data (combinational)
- conv_result  in  WIDTH  converter result
- out_valid  out  1  FIFO head valid
- out_data  out  WIDTH  fixed-point result at FIFO head
- out_ready  in  1  consumer accepts head
- level  out  log2(DEPTH)+1  FIFO occupancy

Behaviour:
- All state updates occur on the rising edge of clk. Reset is synchronous, active-low.
- Reset values: in_ready=0 while reset_n=0, then 1. conv_ce=0. out_valid=0. out_data=0. level=0.
- Reset clears vpipe, inflight, pointers and count. FIFO memory is not reset.
- Define in_fire = in_valid & in_ready.
- in_ready = (count + inflight < DEPTH). Both terms are registered; no combinational path from in_valid or out_ready.
- conv_ce = in_fire | (inflight != 0). Pipeline stops when idle.
- vpipe[LATENCY-1:0]: per-stage valid tag.
  - On an edge with conv_ce=1: vpipe <= {vpipe[LATENCY-2:0], in_fire}.
  - Otherwise vpipe holds.
- wr = vpipe[LATENCY-1]. When wr=1, conv_result is written to FIFO at wr_ptr on that edge.
  - wr=1 implies inflight≥1, which implies conv_ce=1, so the tag shifts out on the same edge. No double write.
- inflight counter (0..LATENCY): +1 on in_fire, -1 on wr; both in the same cycle gives net 0.
- rd = out_valid & out_ready. On rd, the head pops.
- count update: +wr - rd. Simultaneous wr and rd at any count (including DEPTH) are legal.
- Overflow is impossible by credit; implementation asserts (sim only) that count never exceeds DEPTH.
- Pointers wrap modulo DEPTH.
- out_valid = (count != 0), registered-state driven. No write-to-read bypass.
- out_data = out_valid ? mem[rd_ptr] : 0.
- level = count.
- Latency: in_fire edge to out_valid=1 is LATENCY+1 cycles. Throughput is one result per cycle when out_ready is held high.
- Ordering is strictly FIFO.
- Reset mid-operation: in-flight converter contents are abandoned; the converter is not reset, but its outputs are ignored because vpipe is cleared.
  - No spurious out_valid after reset deasserts.
- out_ready with out_valid=0: no effect.
- in_valid with in_ready=0: no accept; upstream holds its data.

Decomposition:
- Shared package ftofix_pkg:
  - FTOFIX_LATENCY (6), FTOFIX_WIDTH (32).
  - Function clog2 for the level/pointer widths.
- One natural sub-module: ftofix_sync_fifo (WIDTH, DEPTH).
  - Write/read ports, count, empty; single clock, synchronous active-low reset.
  - Top level holds vpipe, inflight and credit logic.

Test Plan:
- Test bench uses a behavioural converter model: LATENCY=6, ce-gated pipeline, float to Q16.16.
1. Single item: in_data=0x3FC00000 (1.5), one in_fire, out_ready=1 -> out_valid high exactly 7 cycles later, out_data=0x00018000, for one cycle; conv_ce returns to 0 after wr.
2. Fill: out_ready=0, in_valid held with 0x3F800000,0x40000000,… (1.0,2.0,…,10.0) -> exactly 8 accepted; in_ready=0 from the cycle count+inflight=8; level reaches 8. Then out_ready=1 -> 0x00010000,0x00020000,… pop in order; remaining inputs resume.
3. Streaming: 20 consecutive floats, out_ready=1 -> in_ready never drops, 20 results on consecutive cycles starting at cycle 7, in order.
4. Full plus simultaneous rd/wr: count=7, inflight=1, out_ready=1 on the wr cycle -> level stays 7, no loss, no duplicate.
5. Reset mid-flight: 3 items inflight, 2 in FIFO, reset_n=0 for 1 cycle -> out_valid=0, level=0, conv_ce=0. No out_valid for the following 10 cycles; in_ready=1 after reset.
6. Consumer stall: out_ready toggles 1,0,1,0 during a 10-item stream -> every item delivered once, in order, out_data stable while out_valid=1 and out_ready=0.
